// File: rtl/regbank_dump_unit.sv
// -----------------------------------------------------------------------------
// regbank_dump_unit
//
// Purpose:
//   Debug-side consumer of the register bank read port. A start pulse sweeps
//   bank addresses 0..BANK_DEPTH-1 over the registered debug read path. Each
//   word is captured and sent to the UART transmitter one byte at a time, least
//   significant byte first, with a start/done handshake per byte. The pipeline
//   is expected to be stalled while o_busy is high.
//
// Optional feature (compile-time macro REGBANK_DUMP_CHECKSUM_EN):
//   When defined, a running XOR of every transmitted data byte is kept. It is
//   cleared on an accepted start. After the last data byte, one extra checksum
//   byte is sent with the same handshake before the dump completes. When the
//   macro is undefined, no checksum state or register exists.
//
// Ports:
//   i_clock            in   1        system clock, rising edge
//   i_reset            in   1        asynchronous active-low reset
//   i_start            in   1        pulse: begin dump (ignored while busy)
//   o_rb_read_enable   out  1        bank read enable
//   o_rb_read_address  out  NB_ADDR  bank read address
//   i_rb_data          in   NB_DATA  bank read data (1-cycle registered)
//   o_tx_data          out  NB_BYTE  byte to uart_tx, stable until i_tx_done
//   o_tx_start         out  1        pulse: launch o_tx_data
//   i_tx_done          in   1        pulse: uart_tx finished current byte
//   o_busy             out  1        dump in progress
//   o_done             out  1        pulse: dump complete
// -----------------------------------------------------------------------------
module regbank_dump_unit #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int BANK_DEPTH = 32,
    parameter int NB_BYTE    = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_rb_read_enable,
    output logic [NB_ADDR-1:0] o_rb_read_address,
    input  logic [NB_DATA-1:0] i_rb_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_BYTES = NB_DATA / NB_BYTE;
    localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NB_BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(BANK_DEPTH - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_TX,
        ST_NEXT,
`ifdef REGBANK_DUMP_CHECKSUM_EN
        ST_CSUM,
        ST_CSUM_WAIT,
`endif
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q,  addr_d;
    logic [NB_DATA-1:0] word_q,  word_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
`ifdef REGBANK_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q,  csum_d;
`endif

    // Byte currently selected from the captured word, LSB first.
    logic [NB_BYTE-1:0] cur_byte;
    assign cur_byte = word_q[idx_q*NB_BYTE +: NB_BYTE];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (i_start) state_d = ST_REQ;
            ST_REQ:     state_d = ST_WAIT;
            ST_WAIT:    state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_SEND;
            ST_SEND:    state_d = ST_WAIT_TX;
            // i_tx_done is only honoured here, so a done pulse that
            // coincides with o_tx_start (in SEND) is ignored.
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = (idx_q == LAST_IDX) ? ST_NEXT : ST_SEND;
                end
            end
            ST_NEXT: begin
                if (addr_q == LAST_ADDR) begin
`ifdef REGBANK_DUMP_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_REQ;
                end
            end
`ifdef REGBANK_DUMP_CHECKSUM_EN
            ST_CSUM:      state_d = ST_CSUM_WAIT;
            ST_CSUM_WAIT: if (i_tx_done) state_d = ST_DONE;
`endif
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: address counter, word capture, byte index
    // ------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        word_d = word_q;
        idx_d  = idx_q;
`ifdef REGBANK_DUMP_CHECKSUM_EN
        csum_d = csum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d = '0;
`ifdef REGBANK_DUMP_CHECKSUM_EN
                    csum_d = '0;
`endif
                end
            end
            // Bank output is valid here: address presented in REQ, sampled
            // by the bank at the end of WAIT.
            ST_LOAD: begin
                word_d = i_rb_data;
                idx_d  = '0;
            end
`ifdef REGBANK_DUMP_CHECKSUM_EN
            ST_SEND: csum_d = csum_q ^ cur_byte;
`endif
            ST_WAIT_TX: begin
                if (i_tx_done && (idx_q != LAST_IDX)) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            // Counter saturates at the last address; DONE returns it to 0.
            ST_NEXT: begin
                if (addr_q != LAST_ADDR) begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DONE: addr_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            addr_q <= '0;
            word_q <= '0;
            idx_q  <= '0;
`ifdef REGBANK_DUMP_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            addr_q <= addr_d;
            word_q <= word_d;
            idx_q  <= idx_d;
`ifdef REGBANK_DUMP_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output logic (pure decode of state, so reset clears it at once)
    // ------------------------------------------------------------------
    always_comb begin
        o_rb_read_enable = 1'b0;
        o_tx_data        = '0;
        o_tx_start       = 1'b0;
        o_busy           = 1'b1;
        o_done           = 1'b0;
        unique case (state_q)
            ST_IDLE:    o_busy = 1'b0;
            ST_REQ:     o_rb_read_enable = 1'b1;
            ST_WAIT:    o_rb_read_enable = 1'b1;
            ST_SEND: begin
                o_tx_data  = cur_byte;
                o_tx_start = 1'b1;
            end
            ST_WAIT_TX: o_tx_data = cur_byte;
`ifdef REGBANK_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                o_tx_data  = csum_q;
                o_tx_start = 1'b1;
            end
            ST_CSUM_WAIT: o_tx_data = csum_q;
`endif
            ST_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_rb_read_address = addr_q;

endmodule

// File: tb/tb_regbank_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_regbank_dump_unit
//   Randomised scoreboard bench for regbank_dump_unit. A bank model with a
//   1-cycle registered read port and a uart_tx model with random completion
//   delay surround the DUT. The expected byte stream of each dump is computed
//   from the bank contents and queued at start. A monitor pops one byte per
//   o_tx_start and compares it.
// -----------------------------------------------------------------------------
module tb_regbank_dump_unit;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int DEPTH   = 32;
    localparam int NB_BYTE = 8;
    localparam int BPW     = NB_DATA / NB_BYTE;
`ifdef REGBANK_DUMP_CHECKSUM_EN
    localparam int TOTAL   = DEPTH * BPW + 1;
`else
    localparam int TOTAL   = DEPTH * BPW;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               rb_rd_en;
    logic [NB_ADDR-1:0] rb_addr;
    logic [NB_DATA-1:0] rb_data;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_start;
    logic               tx_done;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    regbank_dump_unit #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .BANK_DEPTH(DEPTH), .NB_BYTE(NB_BYTE)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_start(start),
        .o_rb_read_enable(rb_rd_en),
        .o_rb_read_address(rb_addr),
        .i_rb_data(rb_data),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_done(tx_done),
        .o_busy(busy),
        .o_done(done)
    );

    // Register bank model: registered read output, 1-cycle latency.
    logic [NB_DATA-1:0] bank [DEPTH];
    initial rb_data = '0;
    always @(posedge clk) if (rb_rd_en) rb_data <= bank[rb_addr];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          max_delay = 3;
    bit          spur_en = 1'b0;
    int          bytes_seen = 0;
    int          rd_cycles = 0;
    bit          done_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // uart_tx model: done pulse 1..max_delay cycles after each start; optional
    // spurious done pulses while the bank is being read.
    initial begin : uart_model
        int d;
        bit ab;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst_n && tx_start) begin
                d  = $urandom_range(1, max_delay);
                ab = 1'b0;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) tx_done = 1'b1;
            end else if (rst_n && spur_en && rb_rd_en && ($urandom_range(0, 1) == 1)) begin
                tx_done = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        logic [7:0] held;
        logic [7:0] exp_b;
        bit         outst;
        int         run;
        held  = '0;
        outst = 1'b0;
        run   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                outst = 1'b0;
                run   = 0;
            end else begin
                if (outst && tx_done) outst = 1'b0;
                if (tx_start) begin
                    check("start_overlap", 32'(outst), 32'd0);
                    check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check($sformatf("byte%0d", bytes_seen), 32'(tx_data), 32'(exp_b));
                    end
                    bytes_seen++;
                    held  = tx_data;
                    outst = 1'b1;
                end else if (outst) begin
                    check("tx_data_stable", 32'(tx_data), 32'(held));
                end
                if (rb_rd_en) begin
                    run++;
                    rd_cycles++;
                end else if (run != 0) begin
                    check("rd_en_run", 32'(run), 32'd2);
                    run = 0;
                end
                if (done) begin
                    check("done_queue_empty", 32'(exp_q.size()), 32'd0);
                    check("done_busy_low", 32'(busy), 32'd0);
                    check("rd_en_cycles", 32'(rd_cycles), 32'(2 * DEPTH));
                    done_flag = 1'b1;
                end
            end
        end
    end

    task automatic push_expected();
        logic [7:0] cs;
        logic [NB_DATA-1:0] w;
        exp_q.delete();
        cs = '0;
        for (int a = 0; a < DEPTH; a++) begin
            w = bank[a];
            for (int b = 0; b < BPW; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
`ifdef REGBANK_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic pulse_start();
        push_expected();
        bytes_seen = 0;
        rd_cycles  = 0;
        done_flag  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_dump();
        int c;
        pulse_start();
        c = 0;
        while (!done_flag && c < 60000) begin
            @(negedge clk);
            start = (spur_en && busy && ($urandom_range(0, 15) == 0)) ? 1'b1 : 1'b0;
            c++;
        end
        start = 1'b0;
        check("dump_completed", 32'(done_flag), 32'd1);
        check("bytes_total", 32'(bytes_seen), 32'(TOTAL));
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},   32'(rb_rd_en), 32'd0);
        check({tag, "_addr"},    32'(rb_addr),  32'd0);
        check({tag, "_tx_data"}, 32'(tx_data),  32'd0);
        check({tag, "_tx_start"},32'(tx_start), 32'd0);
        check({tag, "_busy"},    32'(busy),     32'd0);
        check({tag, "_done"},    32'(done),     32'd0);
    endtask

    task automatic load_pattern();
        for (int a = 0; a < DEPTH; a++) bank[a] = '0;
        bank[0] = 32'hffff00ff;
        bank[1] = 32'h01020304;
    endtask

    initial begin : main
        int c;
        rst_n = 1'b0;
        start = 1'b0;
        load_pattern();
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known pattern: ff 00 ff ff 04 03 02 01, then zeros.
        max_delay = 3;
        run_dump();

        // Random contents, long random uart latency, spurious start/done.
        for (int a = 0; a < DEPTH; a++) bank[a] = $urandom;
        max_delay = 200;
        spur_en   = 1'b1;
        run_dump();

        // Last register at the top address, short latencies, spurious events.
        for (int a = 0; a < DEPTH; a++) bank[a] = $urandom;
        bank[DEPTH-1] = 32'hdeadbeef;
        max_delay = 4;
        run_dump();
        spur_en = 1'b0;

        // Abort mid-SEND with reset, then a clean restart from address 0.
        load_pattern();
        max_delay = 2;
        pulse_start();
        c = 0;
        while (bytes_seen < 6 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        while (!tx_start && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("reached_send", 32'(tx_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_outputs_zero("abort_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_dump();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
